// File: rtl/mcu_target_arbiter.sv
// MCU byte-link to per-target command router with latched interrupt aggregation.
// Optional build macro FRAME_TIMEOUT_EN adds an idle-in-frame abort counter.
module mcu_target_arbiter #(
   parameter int NUM_TARGETS    = 4,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     spi_strobe,
   input  logic                     spi_start,
   input  logic [7:0]               spi_din,
   output logic [7:0]               spi_dout,
   output logic [NUM_TARGETS-1:0]   tgt_strobe,
   output logic                     tgt_start,
   output logic [7:0]               tgt_din,
   input  logic [8*NUM_TARGETS-1:0] tgt_dout,
   input  logic [NUM_TARGETS-1:0]   tgt_int,
   output logic                     int_out_n,
   output logic [NUM_TARGETS-1:0]   int_pending,
   output logic                     frame_abort
);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_FWD, S_LOCAL, S_DISCARD} state_t;

   if (NUM_TARGETS < 1 || NUM_TARGETS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("mcu_target_arbiter: parameter out of range");
   end

   state_t                 r_state;
   logic [7:0]             r_sel;
   logic [NUM_TARGETS-1:0] r_int_hist;
   logic [NUM_TARGETS-1:0] r_snap;
   logic [NUM_TARGETS-1:0] w_onehot;
   logic [NUM_TARGETS-1:0] w_rise;
   logic [NUM_TARGETS-1:0] w_ack;
   logic                   w_ack_v;
   logic                   w_sel_valid;
   logic                   w_byte;
   logic                   w_timeout;
   logic [7:0]             w_fwd_dout;

   genvar gi;
   for (gi = 0; gi < NUM_TARGETS; gi++) begin : g_sel
      assign w_onehot[gi] = (r_sel == 8'(gi));
   end

   assign w_sel_valid = (r_sel < 8'(NUM_TARGETS));
   assign w_byte      = spi_strobe && !spi_start;
   assign w_rise      = tgt_int & ~r_int_hist;
   // Ack bytes are the header-following byte of an 0xFF frame and every byte after it.
   assign w_ack_v     = w_byte && (r_state == S_LOCAL || (r_state == S_HDR && r_sel == 8'hFF));
   assign w_ack       = w_ack_v ? spi_din[NUM_TARGETS-1:0] : '0;

   always_comb begin
      w_fwd_dout = 8'h00;
      for (int i = 0; i < NUM_TARGETS; i++) begin
         if (w_onehot[i]) w_fwd_dout = tgt_dout[8*i +: 8];
      end
   end

   always_comb begin
      spi_dout = 8'h00;
      case (r_state)
         S_FWD:   spi_dout = w_fwd_dout;
         S_HDR:   spi_dout = 8'h5A;
         S_LOCAL: spi_dout = 8'(r_snap);
         default: spi_dout = 8'h00;
      endcase
   end

`ifdef FRAME_TIMEOUT_EN
   logic [31:0] r_cnt;
   logic        r_abort;

   assign w_timeout   = (r_state != S_IDLE) && !spi_strobe && (r_cnt == 32'(TIMEOUT_CYCLES - 1));
   assign frame_abort = r_abort;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_abort <= 1'b0;
      end else begin
         r_abort <= w_timeout;
         if (spi_strobe || w_timeout || r_state == S_IDLE) r_cnt <= '0;
         else                                               r_cnt <= r_cnt + 32'd1;
      end
   end
`else
   assign w_timeout   = 1'b0;
   assign frame_abort = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_sel      <= 8'h00;
         tgt_strobe <= '0;
         tgt_start  <= 1'b0;
         tgt_din    <= 8'h00;
      end else begin
         tgt_strobe <= '0;
         if (spi_strobe && spi_start) begin
            r_sel   <= spi_din;
            r_state <= S_HDR;
         end else if (w_byte) begin
            case (r_state)
               S_HDR: begin
                  if (w_sel_valid) begin
                     tgt_strobe <= w_onehot;
                     tgt_start  <= 1'b1;
                     tgt_din    <= spi_din;
                     r_state    <= S_FWD;
                  end else if (r_sel == 8'hFF) begin
                     r_state <= S_LOCAL;
                  end else begin
                     r_state <= S_DISCARD;
                  end
               end
               S_FWD: begin
                  tgt_strobe <= w_onehot;
                  tgt_start  <= 1'b0;
                  tgt_din    <= spi_din;
               end
               default: ;
            endcase
         end else if (w_timeout) begin
            r_state <= S_IDLE;
         end
      end
   end

   // A rising request in the same cycle as its ack leaves the bit set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_int_hist  <= '0;
         r_snap      <= '0;
         int_pending <= '0;
         int_out_n   <= 1'b1;
      end else begin
         r_int_hist  <= tgt_int;
         int_pending <= (int_pending & ~w_ack) | w_rise;
         int_out_n   <= ~|int_pending;
         if (w_ack_v) r_snap <= int_pending;
      end
   end

endmodule

// File: tb/tb_mcu_target_arbiter.sv
// Randomized self-checking bench for mcu_target_arbiter against a frame-level reference model.
module tb_mcu_target_arbiter;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           spi_strobe, spi_start;
   logic [7:0]     spi_din, spi_dout;
   logic [N-1:0]   tgt_strobe;
   logic           tgt_start;
   logic [7:0]     tgt_din;
   logic [8*N-1:0] tgt_dout;
   logic [N-1:0]   tgt_int;
   logic           int_out_n;
   logic [N-1:0]   int_pending;
   logic           frame_abort;

   mcu_target_arbiter #(.NUM_TARGETS(N), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset),
      .spi_strobe(spi_strobe), .spi_start(spi_start), .spi_din(spi_din), .spi_dout(spi_dout),
      .tgt_strobe(tgt_strobe), .tgt_start(tgt_start), .tgt_din(tgt_din), .tgt_dout(tgt_dout),
      .tgt_int(tgt_int), .int_out_n(int_out_n), .int_pending(int_pending), .frame_abort(frame_abort)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: frame bookkeeping plus interrupt pending rules.
   bit           f_open = 0;
   logic [7:0]   f_sel  = 8'h00;
   int           f_cnt  = 0;
   logic [N-1:0] m_pend, m_prev, m_snap, m_ack;
   logic         m_intn, m_ack_v;
   logic [8*N-1:0] td_next;

   always @(posedge clk) begin
      if (reset) begin
         m_pend = '0; m_prev = '0; m_intn = 1'b1; m_snap = '0;
      end else begin
         m_intn = (m_pend == '0);
         if (m_ack_v) m_snap = m_pend;
         m_pend = (m_pend & ~m_ack) | (tgt_int & ~m_prev);
         m_prev = tgt_int;
      end
   end

   task automatic xfer(input bit st, input logic [7:0] d, input logic [N-1:0] iv);
      logic [N-1:0] e_strb;
      logic         e_start;
      logic [7:0]   e_dout;
      e_strb  = '0;
      e_start = 1'b0;
      @(negedge clk);
      if (st) begin
         f_open = 1; f_sel = d; f_cnt = 0;
      end else if (f_open) begin
         if (f_sel < N) begin
            e_strb  = N'(1) << f_sel;
            e_start = (f_cnt == 0);
         end else if (f_sel == 8'hFF) begin
            m_ack   = d[N-1:0];
            m_ack_v = 1'b1;
         end
         f_cnt++;
      end
      spi_strobe = 1'b1; spi_start = st; spi_din = d; tgt_int = iv; tgt_dout = td_next;
      @(negedge clk);
      spi_strobe = 1'b0; spi_start = 1'b0; m_ack_v = 1'b0; m_ack = '0;
      if (!f_open)              e_dout = 8'h00;
      else if (f_cnt == 0)      e_dout = 8'h5A;
      else if (f_sel < N)       e_dout = tgt_dout[8*f_sel +: 8];
      else if (f_sel == 8'hFF)  e_dout = 8'(m_snap);
      else                      e_dout = 8'h00;
      check_val("tgt_strobe", 32'(tgt_strobe), 32'(e_strb));
      if (e_strb != '0) begin
         check_val("tgt_start", 32'(tgt_start), 32'(e_start));
         check_val("tgt_din", 32'(tgt_din), 32'(d));
      end
      check_val("spi_dout", 32'(spi_dout), 32'(e_dout));
      check_val("int_pending", 32'(int_pending), 32'(m_pend));
      check_val("int_out_n", 32'(int_out_n), 32'(m_intn));
      check_val("frame_abort", 32'(frame_abort), 32'd0);
      @(negedge clk);
      check_val("strobe_1clk", 32'(tgt_strobe), 32'd0);
      $display("xfer start=%0d din=0x%02h int=0x%0h -> strobe=0x%0h start=%0d tdin=0x%02h dout=0x%02h pend=0x%0h",
               st, d, iv, e_strb, e_start, d, spi_dout, int_pending);
   endtask

   logic [7:0] hdr_tab [8];

   initial begin
      hdr_tab[0] = 8'h00; hdr_tab[1] = 8'h01; hdr_tab[2] = 8'h02; hdr_tab[3] = 8'h03;
      hdr_tab[4] = 8'hFF; hdr_tab[5] = 8'hFF; hdr_tab[6] = 8'h07; hdr_tab[7] = 8'h80;
      reset = 1'b1; spi_strobe = 1'b0; spi_start = 1'b0; spi_din = 8'h00;
      tgt_dout = '0; tgt_int = '0; td_next = 32'h44332211; m_ack = '0; m_ack_v = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_val("rst_strobe", 32'(tgt_strobe), 32'd0);
      check_val("rst_start", 32'(tgt_start), 32'd0);
      check_val("rst_din", 32'(tgt_din), 32'd0);
      check_val("rst_dout", 32'(spi_dout), 32'd0);
      check_val("rst_pending", 32'(int_pending), 32'd0);
      check_val("rst_int_n", 32'(int_out_n), 32'd1);
      check_val("rst_abort", 32'(frame_abort), 32'd0);

      xfer(0, 8'h12, 4'h0);                       // idle non-start byte ignored
      xfer(1, 8'h01, 4'h0); xfer(0, 8'h04, 4'h0); xfer(0, 8'h56, 4'h0); xfer(0, 8'h01, 4'h0);
      td_next = 32'h005C0000;
      xfer(1, 8'h02, 4'h0); xfer(0, 8'hAA, 4'h0);
      check_val("fwd_t2_dout", 32'(spi_dout), 32'h5C);
      xfer(1, 8'h00, 4'h8);                       // rising edge on int[3]
      check_val("int3_pend", 32'(int_pending), 32'h8);
      xfer(1, 8'hFF, 4'h8); xfer(0, 8'h08, 4'h8);
      check_val("local_ret", 32'(spi_dout), 32'h08);
      xfer(1, 8'hFF, 4'h8); xfer(0, 8'h01, 4'h9); // set and ack bit0 together
      check_val("conflict", 32'(int_pending[0]), 32'd1);
      xfer(0, 8'h01, 4'h9);
      xfer(1, 8'h07, 4'h9); xfer(0, 8'h33, 4'h9); xfer(0, 8'h34, 4'h9);
      xfer(1, 8'h00, 4'h9); xfer(0, 8'h44, 4'h9);
      xfer(1, 8'h01, 4'h9); xfer(0, 8'h11, 4'h9); xfer(1, 8'h00, 4'h9); xfer(0, 8'h22, 4'h9);

`ifdef FRAME_TIMEOUT_EN
      begin
         int pulses;
         pulses = 0;
         xfer(1, 8'h01, tgt_int);
         for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (frame_abort) pulses++;
         end
         f_open = 0;
         check_val("abort_pulses", 32'(pulses), 32'd1);
         check_val("abort_dout", 32'(spi_dout), 32'd0);
         xfer(0, 8'h55, tgt_int);
      end
`endif

      for (int t = 0; t < 250; t++) begin
         bit           st;
         logic [7:0]   d;
         logic [N-1:0] iv;
         st = ($urandom_range(0, 3) == 0);
         d  = st ? hdr_tab[$urandom_range(0, 7)] : 8'($urandom);
         iv = tgt_int;
         if ($urandom_range(0, 2) == 0) iv = iv ^ N'($urandom);
         td_next = $urandom;
         xfer(st, d, iv);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
